// File: rtl/ecsu_pkg.sv
// Shared state encoding and sizing helpers for the environmental condition monitor.
package ecsu_pkg;

    typedef enum logic [1:0] {
        ALL_CLEAR  = 2'd0,
        CAUTION    = 2'd1,
        HIGH_ALERT = 2'd2,
        EMERGENCY  = 2'd3
    } zone_state_e;

    localparam int STATE_W = 2;
    localparam int VIS_W   = 2;

    localparam logic [VIS_W-1:0] VIS_CLEAR = 2'd0;
    localparam logic [VIS_W-1:0] VIS_NONE  = 2'd3;

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int zone_idx_width(input int num_zones);
        return (num_zones > 1) ? $clog2(num_zones) : 1;
    endfunction

endpackage

// File: rtl/ecsu_zone_fsm.sv
// One weather zone: classifier, debounce/dwell counters and the latched-emergency state machine.
module ecsu_zone_fsm
    import ecsu_pkg::*;
#(
    parameter int WIND_W       = 6,
    parameter int TEMP_W       = 8,
    parameter int CAUTION_WIND = 10,
    parameter int ALERT_WIND   = 15,
    parameter int EMERG_WIND   = 20,
    parameter int ALERT_TEMP   = 35,
    parameter int EMERG_TEMP   = 40,
    parameter int DEBOUNCE     = 3,
    parameter int CLEAR_DWELL  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              sample_valid,
    input  logic              thunderstorm,
    input  logic [WIND_W-1:0] wind,
    input  logic [VIS_W-1:0]  visibility,
    input  logic [TEMP_W-1:0] temperature,
    input  logic              ack,
    output zone_state_e       state,
    output logic              severe_weather,
    output logic              emergency_landing_alert
);

    localparam int CW = cnt_width((DEBOUNCE > CLEAR_DWELL) ? DEBOUNCE : CLEAR_DWELL);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0] ESC_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(CLEAR_DWELL - 1);

    zone_state_e   state_r, state_s;
    zone_state_e   last_tgt_r, last_tgt_s;
    zone_state_e   tgt_s;
    logic [CW-1:0] esc_cnt_r, esc_cnt_s;
    logic [CW-1:0] dwell_cnt_r, dwell_cnt_s;
    int            wind_v_s;
    int            temp_v_s;

    // Classify the current sample; wind is unsigned, temperature is sign-extended.
    always_comb begin
        wind_v_s = int'(wind);
        temp_v_s = int'($signed(temperature));
        if (wind_v_s > EMERG_WIND || temp_v_s > EMERG_TEMP || temp_v_s < -EMERG_TEMP) begin
            tgt_s = EMERGENCY;
        end else if (thunderstorm || wind_v_s > ALERT_WIND || temp_v_s > ALERT_TEMP ||
                     temp_v_s < -ALERT_TEMP || visibility == VIS_NONE) begin
            tgt_s = HIGH_ALERT;
        end else if (wind_v_s > CAUTION_WIND || visibility != VIS_CLEAR) begin
            tgt_s = CAUTION;
        end else begin
            tgt_s = ALL_CLEAR;
        end
    end

    // State, counter and last-target registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ALL_CLEAR;
            last_tgt_r  <= ALL_CLEAR;
            esc_cnt_r   <= CNT_ZERO;
            dwell_cnt_r <= CNT_ZERO;
        end else begin
            state_r     <= state_s;
            last_tgt_r  <= last_tgt_s;
            esc_cnt_r   <= esc_cnt_s;
            dwell_cnt_r <= dwell_cnt_s;
        end
    end

    // Next state: the acknowledge exit looks at the registered target and wins over counting.
    always_comb begin
        state_s     = state_r;
        esc_cnt_s   = esc_cnt_r;
        dwell_cnt_s = dwell_cnt_r;
        if (sample_valid) begin
            last_tgt_s = tgt_s;
        end else begin
            last_tgt_s = last_tgt_r;
        end
        if (ack && state_r == EMERGENCY && last_tgt_r != EMERGENCY) begin
            state_s     = HIGH_ALERT;
            esc_cnt_s   = CNT_ZERO;
            dwell_cnt_s = CNT_ZERO;
        end else if (!sample_valid) begin
            state_s = state_r;
        end else if (tgt_s > state_r) begin
            dwell_cnt_s = CNT_ZERO;
            if (esc_cnt_r == ESC_LAST) begin
                state_s   = tgt_s;
                esc_cnt_s = CNT_ZERO;
            end else if (esc_cnt_r != CNT_MAX) begin
                esc_cnt_s = esc_cnt_r + CNT_ONE;
            end else begin
                esc_cnt_s = esc_cnt_r;
            end
        end else if (tgt_s < state_r && state_r != EMERGENCY) begin
            esc_cnt_s = CNT_ZERO;
            if (dwell_cnt_r == DWELL_LAST) begin
                state_s     = zone_state_e'(state_r - 2'd1);
                dwell_cnt_s = CNT_ZERO;
            end else if (dwell_cnt_r != CNT_MAX) begin
                dwell_cnt_s = dwell_cnt_r + CNT_ONE;
            end else begin
                dwell_cnt_s = dwell_cnt_r;
            end
        end else begin
            esc_cnt_s   = CNT_ZERO;
            dwell_cnt_s = CNT_ZERO;
        end
    end

    // Output decode straight from the state register.
    always_comb begin
        state                   = state_r;
        severe_weather          = (state_r >= HIGH_ALERT);
        emergency_landing_alert = (state_r == EMERGENCY);
    end

endmodule

// File: rtl/env_condition_monitor.sv
// Multi-zone weather monitor: one zone FSM per zone plus worst-case aggregation.
module env_condition_monitor
    import ecsu_pkg::*;
#(
    parameter int NUM_ZONES    = 4,
    parameter int WIND_W       = 6,
    parameter int TEMP_W       = 8,
    parameter int CAUTION_WIND = 10,
    parameter int ALERT_WIND   = 15,
    parameter int EMERG_WIND   = 20,
    parameter int ALERT_TEMP   = 35,
    parameter int EMERG_TEMP   = 40,
    parameter int DEBOUNCE     = 3,
    parameter int CLEAR_DWELL  = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              sample_valid,
    input  logic [NUM_ZONES-1:0]              thunderstorm,
    input  logic [NUM_ZONES*WIND_W-1:0]       wind,
    input  logic [NUM_ZONES*VIS_W-1:0]        visibility,
    input  logic [NUM_ZONES*TEMP_W-1:0]       temperature,
    input  logic [NUM_ZONES-1:0]              ack,
    output logic [NUM_ZONES*STATE_W-1:0]      zone_state,
    output logic [NUM_ZONES-1:0]              severe_weather,
    output logic [NUM_ZONES-1:0]              emergency_landing_alert,
    output logic [STATE_W-1:0]                worst_state,
    output logic [zone_idx_width(NUM_ZONES)-1:0] worst_zone,
    output logic                              any_emergency
);

    localparam int ZONE_W = zone_idx_width(NUM_ZONES);

    zone_state_e zs_s [NUM_ZONES];

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        ecsu_zone_fsm #(
            .WIND_W      (WIND_W),
            .TEMP_W      (TEMP_W),
            .CAUTION_WIND(CAUTION_WIND),
            .ALERT_WIND  (ALERT_WIND),
            .EMERG_WIND  (EMERG_WIND),
            .ALERT_TEMP  (ALERT_TEMP),
            .EMERG_TEMP  (EMERG_TEMP),
            .DEBOUNCE    (DEBOUNCE),
            .CLEAR_DWELL (CLEAR_DWELL)
        ) u_zone (
            .CLK                    (CLK),
            .RST                    (RST),
            .sample_valid           (sample_valid),
            .thunderstorm           (thunderstorm[z]),
            .wind                   (wind[z*WIND_W +: WIND_W]),
            .visibility             (visibility[z*VIS_W +: VIS_W]),
            .temperature            (temperature[z*TEMP_W +: TEMP_W]),
            .ack                    (ack[z]),
            .state                  (zs_s[z]),
            .severe_weather         (severe_weather[z]),
            .emergency_landing_alert(emergency_landing_alert[z])
        );
        assign zone_state[z*STATE_W +: STATE_W] = zs_s[z];
    end

    // Worst state across zones; strict compare keeps the lowest index on ties.
    always_comb begin
        worst_state = zs_s[0];
        worst_zone  = {ZONE_W{1'b0}};
        for (int z = 1; z < NUM_ZONES; z++) begin
            if (zs_s[z] > worst_state) begin
                worst_state = zs_s[z];
                worst_zone  = ZONE_W'(z);
            end else begin
                worst_state = worst_state;
            end
        end
        any_emergency = |emergency_landing_alert;
    end

endmodule

// File: tb/tb_env_condition_monitor.sv
// Vector-table bench with an expected-result queue for env_condition_monitor.
module tb_env_condition_monitor;

    logic        CLK = 1'b0;
    logic        RST;
    logic        sample_valid;
    logic [3:0]  thunderstorm;
    logic [23:0] wind;
    logic [7:0]  visibility;
    logic [31:0] temperature;
    logic [3:0]  ack;
    logic [7:0]  zone_state;
    logic [3:0]  severe_weather;
    logic [3:0]  emergency_landing_alert;
    logic [1:0]  worst_state;
    logic [1:0]  worst_zone;
    logic        any_emergency;

    env_condition_monitor #(
        .NUM_ZONES(4), .WIND_W(6), .TEMP_W(8),
        .CAUTION_WIND(10), .ALERT_WIND(15), .EMERG_WIND(20),
        .ALERT_TEMP(35), .EMERG_TEMP(40),
        .DEBOUNCE(3), .CLEAR_DWELL(4)
    ) dut (
        .CLK(CLK), .RST(RST), .sample_valid(sample_valid),
        .thunderstorm(thunderstorm), .wind(wind), .visibility(visibility),
        .temperature(temperature), .ack(ack),
        .zone_state(zone_state), .severe_weather(severe_weather),
        .emergency_landing_alert(emergency_landing_alert),
        .worst_state(worst_state), .worst_zone(worst_zone),
        .any_emergency(any_emergency)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic [3:0]  ack;
        logic [23:0] wind;
        logic [31:0] temp;
        logic [7:0]  vis;
        logic [3:0]  thunder;
        logic [7:0]  exp_zs;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] zs;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    int         w [4];
    int         t [4];
    int         v [4];
    logic [3:0] th;

    function automatic logic [7:0] zs4(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    // Expected full output vector derived from the expected zone states.
    function automatic logic [20:0] decode(input logic [7:0] zs);
        logic [3:0] sev;
        logic [3:0] emg;
        logic [1:0] ws;
        logic [1:0] wz;
        logic [1:0] s;
        ws = zs[1:0];
        wz = 2'd0;
        for (int z = 0; z < 4; z++) begin
            s      = zs[2*z +: 2];
            sev[z] = (s >= 2'd2);
            emg[z] = (s == 2'd3);
            if (s > ws) begin
                ws = s;
                wz = 2'(z);
            end
        end
        return {zs, sev, emg, ws, wz, |emg};
    endfunction

    task automatic benign();
        for (int z = 0; z < 4; z++) begin
            w[z] = 0;
            t[z] = 20;
            v[z] = 0;
        end
        th = 4'b0000;
    endtask

    task automatic add(input string nm, input logic r, input logic vd,
                       input logic [3:0] ak, input logic [7:0] ez);
        vec_t rec;
        rec.name    = nm;
        rec.rst     = r;
        rec.valid   = vd;
        rec.ack     = ak;
        rec.thunder = th;
        rec.exp_zs  = ez;
        for (int z = 0; z < 4; z++) begin
            rec.wind[z*6 +: 6] = 6'(w[z]);
            rec.temp[z*8 +: 8] = 8'(t[z]);
            rec.vis[z*2 +: 2]  = 2'(v[z]);
        end
        vecs.push_back(rec);
    endtask

    // n valid samples with unchanged inputs: all but the last expect `hold`.
    task automatic add_n(input string nm, input int n, input logic [7:0] hold,
                         input logic [7:0] last);
        for (int i = 0; i < n - 1; i++) add(nm, 1'b0, 1'b1, 4'b0000, hold);
        add(nm, 1'b0, 1'b1, 4'b0000, last);
    endtask

    task automatic check_prev();
        exp_t       e;
        logic [20:0] act;
        logic [20:0] req;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {zone_state, severe_weather, emergency_landing_alert,
                   worst_state, worst_zone, any_emergency};
            req = decode(e.zs);
            tests++;
            if (act !== req) begin
                fails++;
                $display("FAIL %s: got zs=%b sev=%b emg=%b ws=%0d wz=%0d any=%b, want zs=%b sev=%b emg=%b ws=%0d wz=%0d any=%b",
                         e.name, act[20:13], act[12:9], act[8:5], act[4:3], act[2:1], act[0],
                         req[20:13], req[12:9], req[8:5], req[4:3], req[2:1], req[0]);
            end
        end
    endtask

    initial begin
        RST = 1'b1; sample_valid = 1'b0; thunderstorm = 4'b0; wind = 24'd0;
        visibility = 8'd0; temperature = 32'd0; ack = 4'b0;

        // Reset, then zone0 debounce with an interrupted run.
        benign();
        w[0] = 16;
        add("reset", 1'b1, 1'b1, 4'b0000, zs4(0,0,0,0));
        add_n("z0_two", 2, zs4(0,0,0,0), zs4(0,0,0,0));
        w[0] = 5;
        add("z0_break", 1'b0, 1'b1, 4'b0000, zs4(0,0,0,0));
        w[0] = 16;
        add_n("z0_esc", 3, zs4(0,0,0,0), zs4(2,0,0,0));

        // Zone2 caution with invalid cycles carrying a wilder wind value.
        w[2] = 12; add("z2_v1", 1'b0, 1'b1, 4'b0000, zs4(2,0,0,0));
        w[2] = 30; add("z2_inv", 1'b0, 1'b0, 4'b0000, zs4(2,0,0,0));
        w[2] = 12; add("z2_v2", 1'b0, 1'b1, 4'b0000, zs4(2,0,0,0));
        w[2] = 30; add("z2_inv", 1'b0, 1'b0, 4'b0000, zs4(2,0,0,0));
        add("z2_inv", 1'b0, 1'b0, 4'b0000, zs4(2,0,0,0));
        w[2] = 12; add("z2_v3", 1'b0, 1'b1, 4'b0000, zs4(2,0,1,0));
        w[3] = 16;
        add_n("z3_esc", 3, zs4(2,0,1,0), zs4(2,0,1,2));

        // Zone1 cold emergency, latched, acked, then dwelling down.
        t[1] = -41;
        add_n("z1_emerg", 3, zs4(2,0,1,2), zs4(2,3,1,2));
        t[1] = 20;
        add_n("z1_latched", 10, zs4(2,3,1,2), zs4(2,3,1,2));
        add("z1_ack", 1'b0, 1'b0, 4'b0010, zs4(2,2,1,2));
        add_n("z1_dwell_a", 4, zs4(2,2,1,2), zs4(2,1,1,2));
        add_n("z1_dwell_b", 4, zs4(2,1,1,2), zs4(2,0,1,2));

        // Ack against an emergency target, and ack racing a sample.
        t[1] = 45;
        add_n("z1_hot", 3, zs4(2,0,1,2), zs4(2,3,1,2));
        add("ack_tgt3", 1'b0, 1'b1, 4'b0010, zs4(2,3,1,2));
        t[1] = 20;
        add("ack_preupd", 1'b0, 1'b1, 4'b0010, zs4(2,3,1,2));
        add("ack_exit", 1'b0, 1'b0, 4'b0010, zs4(2,2,1,2));
        add("ack_in_ha", 1'b0, 1'b0, 4'b0010, zs4(2,2,1,2));
        t[1] = -41;
        add_n("z1_reemerg", 3, zs4(2,2,1,2), zs4(2,3,1,2));

        // Reset overriding ack/valid, and clearing a partial debounce.
        add("rst_emerg", 1'b1, 1'b1, 4'b0010, zs4(0,0,0,0));
        benign();
        w[0] = 16;
        add_n("post_rst", 2, zs4(0,0,0,0), zs4(0,0,0,0));
        add("rst_mid", 1'b1, 1'b1, 4'b0000, zs4(0,0,0,0));
        add_n("after_mid", 3, zs4(0,0,0,0), zs4(2,0,0,0));

        // Classifier thresholds: values exactly at a limit do not cross it.
        add("rst_cls", 1'b1, 1'b0, 4'b0000, zs4(0,0,0,0));
        benign();
        w[0] = 20; t[1] = 40; v[2] = 3; t[3] = -40;
        add_n("cls_edge", 3, zs4(0,0,0,0), zs4(2,2,2,2));
        w[0] = 21; t[1] = 20; th = 4'b0010; v[2] = 1; t[3] = 20; w[3] = 11;
        add_n("cls_mix", 3, zs4(2,2,2,2), zs4(3,2,2,2));
        add("cls_drop", 1'b0, 1'b1, 4'b0000, zs4(3,2,1,1));
        add("z0_ack_ign", 1'b0, 1'b0, 4'b0001, zs4(3,2,1,1));
        w[0] = 10;
        add("z0_ack_race", 1'b0, 1'b1, 4'b0001, zs4(3,2,1,1));
        add("z0_ack_exit", 1'b0, 1'b0, 4'b0001, zs4(2,2,1,1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            check_prev();
            RST          = vecs[i].rst;
            sample_valid = vecs[i].valid;
            ack          = vecs[i].ack;
            wind         = vecs[i].wind;
            temperature  = vecs[i].temp;
            visibility   = vecs[i].vis;
            thunderstorm = vecs[i].thunder;
            exp_q.push_back('{vecs[i].name, vecs[i].exp_zs});
        end
        @(negedge CLK);
        check_prev();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/env_condition_monitor.md
ENV_CONDITION_MONITOR -- requirements
Module: env_condition_monitor

Interface
REQ-001 SHALL have parameter NUM_ZONES, default 4, number of independent weather zones (>=1).
REQ-002 SHALL have parameter WIND_W, default 6, unsigned wind field width per zone.
REQ-003 SHALL have parameter TEMP_W, default 8, signed two's-complement temperature field width per zone.
REQ-004 SHALL have parameters CAUTION_WIND=10, ALERT_WIND=15, EMERG_WIND=20, ALERT_TEMP=35, EMERG_TEMP=40, classification thresholds; CAUTION_WIND<ALERT_WIND<EMERG_WIND and ALERT_TEMP<EMERG_TEMP.
REQ-005 SHALL have parameter DEBOUNCE, default 3, consecutive valid samples required to escalate (>=1).
REQ-006 SHALL have parameter CLEAR_DWELL, default 8, consecutive valid samples required to de-escalate one level (>=1).
REQ-007 CLK  input  1  clock; all state changes on rising edge.
REQ-008 RST  input  1  reset, synchronous, active-high.
REQ-009 sample_valid  input  1  all zone sensor fields valid this cycle.
REQ-010 thunderstorm  input  NUM_ZONES  per-zone thunderstorm flag.
REQ-011 wind  input  NUM_ZONES*WIND_W  per-zone wind, zone z at bits [z*WIND_W +: WIND_W].
REQ-012 visibility  input  NUM_ZONES*2  per-zone visibility code (0 clear, 1 reduced, 2 poor, 3 none).
REQ-013 temperature  input  NUM_ZONES*TEMP_W  per-zone signed temperature.
REQ-014 ack  input  NUM_ZONES  per-zone operator acknowledge of emergency.
REQ-015 zone_state  output  NUM_ZONES*2  per-zone state.
REQ-016 severe_weather  output  NUM_ZONES  zone state >= HIGH_ALERT.
REQ-017 emergency_landing_alert  output  NUM_ZONES  zone state == EMERGENCY.
REQ-018 worst_state  output  2  maximum state over all zones.
REQ-019 worst_zone  output  max(1,$clog2(NUM_ZONES))  lowest zone index holding worst_state.
REQ-020 any_emergency  output  1  OR of emergency_landing_alert.

Function
REQ-021 States SHALL be ALL_CLEAR=0, CAUTION=1, HIGH_ALERT=2, EMERGENCY=3, ordered by severity.
REQ-022 Per-zone target SHALL be: EMERGENCY if wind>EMERG_WIND or temp>EMERG_TEMP or temp<-EMERG_TEMP; else HIGH_ALERT if thunderstorm or wind>ALERT_WIND or temp>ALERT_TEMP or temp<-ALERT_TEMP or visibility==3; else CAUTION if wind>CAUTION_WIND or visibility in {1,2}; else ALL_CLEAR.
REQ-023 Temperature comparisons SHALL be signed; wind comparisons unsigned.
REQ-024 Cycles with sample_valid=0 SHALL leave states, counters and last_tgt unchanged.
REQ-025 Each valid sample SHALL store target into per-zone last_tgt register.
REQ-026 Valid sample with target>state: clear dwell counter, increment escalate counter; on the DEBOUNCE-th consecutive such sample state SHALL jump directly to that sample's target at the same edge, counters cleared.
REQ-027 Valid sample with target<state (state!=EMERGENCY): clear escalate counter, increment dwell counter; on CLEAR_DWELL-th consecutive such sample state SHALL drop exactly one level, counters cleared.
REQ-028 Valid sample with target==state SHALL clear both counters.
REQ-029 EMERGENCY SHALL be latched: valid samples do not de-escalate it; exit only when ack[z]=1 and registered last_tgt<EMERGENCY, to HIGH_ALERT next edge, counters cleared.
REQ-030 ack in any other state, or with last_tgt==EMERGENCY, SHALL be ignored.
REQ-031 ack and sample_valid in same cycle: ack SHALL evaluate pre-update last_tgt; ack exit takes priority over sample counting.
REQ-032 Counters SHALL saturate and never wrap.
REQ-033 severe_weather, emergency_landing_alert, worst_state, worst_zone, any_emergency SHALL be combinational decodes of the state registers (zero added latency).

Reset
REQ-034 RST SHALL set every zone state ALL_CLEAR, all counters 0, last_tgt ALL_CLEAR; all outputs read 0 the cycle after.
REQ-035 RST SHALL override sample_valid and ack in the same cycle, including mid-debounce and in EMERGENCY.

Structure
REQ-036 State encodings and width constants SHALL live in shared package ecsu_pkg.
REQ-037 Per-zone FSM, counters and classifier SHALL be sub-module ecsu_zone_fsm, instantiated NUM_ZONES times; top holds aggregation only.

Verification (NUM_ZONES=4, DEBOUNCE=3, CLEAR_DWELL=4)
REQ-038 Zone0 wind=16 for 3 valid samples -> zone_state[0]=2, severe_weather[0]=1 after third; only 2 samples then wind=5 -> stays 0.
REQ-039 Zone1 temp=-41 x3 -> EMERGENCY, any_emergency=1; temp=20 x10 -> still 3; ack[1] -> 2 next cycle; 4 clear samples -> 1; 4 more -> 0.
REQ-040 Zone2 wind=12 on valid samples interleaved with sample_valid=0 cycles -> CAUTION only after third valid sample.
REQ-041 Zones {0,2,3}={2,1,2} -> worst_state=2, worst_zone=0; ack[1] while temp=45 (last_tgt=3) -> zone1 stays EMERGENCY.
REQ-042 RST with zone1 EMERGENCY and ack[1]=1 -> all zone_state=0, all outputs 0 next cycle; subsequent 2 samples of wind=16 -> no escalation.
